// File: rtl/pe_ld_fc_pkg.sv
// Shared defaults for the PE load flow-control slice: channel count, data width,
// response FIFO depth and stall counter width.
package pe_ld_fc_pkg;
  localparam int N_CH_DEF       = 2;
  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 2;
  localparam int STALL_W_DEF    = 8;
  localparam int PTR_W          = $clog2(FIFO_DEPTH_DEF);
endpackage

// File: rtl/pe_ld_ch_fifo.sv
// First-word-fall-through response FIFO for one load channel. Pushes while full
// and pops while empty are ignored; the head reads as zero when empty.
module pe_ld_ch_fifo
  import pe_ld_fc_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign full      = (cnt == (PW+1)'(FIFO_DEPTH));
  assign empty     = (cnt == '0);
  assign do_push   = push & ~full & ~rst;
  assign do_pop    = pop & ~empty & ~rst;
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage carries no reset; the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    cnt <= (PW+1)'(FIFO_DEPTH));
endmodule

// File: rtl/pe_func_unit_ld_flow_ctrl_mc.sv
// Multi-channel load flow control: buffers early load responses per channel and
// releases the functional-unit register once every enabled channel has data.
module pe_func_unit_ld_flow_ctrl_mc
  import pe_ld_fc_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int STALL_W    = STALL_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        ifc_en,
  input  logic                   instr_done,
  output logic                   ifc_unblocked,
  output logic                   reg_en,
  output logic [N_CH-1:0]        func_unit_rdy,
  input  logic [N_CH-1:0]        mem_vld,
  input  logic [N_CH*DATA_W-1:0] mem_data,
  output logic [N_CH-1:0]        mem_rdy,
  output logic [N_CH*DATA_W-1:0] rd_data,
  output logic [STALL_W-1:0]     stall_cnt,
  output logic                   ovf_err
);
  logic [N_CH-1:0] empty;
  logic [N_CH-1:0] full;
  logic [N_CH-1:0] ch_ok;
  logic [N_CH-1:0] push;
  logic            any_en;
  logic            blocked;

  // Ready is conservative: a same-cycle pop never opens a slot for a push.
  assign mem_rdy = ~full;
  assign push    = mem_vld & mem_rdy;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pe_ld_ch_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[c]),
      .push_data(mem_data[c*DATA_W +: DATA_W]),
      .pop      (func_unit_rdy[c]),
      .head_data(rd_data[c*DATA_W +: DATA_W]),
      .empty    (empty[c]),
      .full     (full[c])
    );
  end

  assign ch_ok         = ~ifc_en | ~empty;
  assign ifc_unblocked = &ch_ok;
  assign any_en        = |ifc_en;
  assign reg_en        = ~rst & any_en & instr_done & ifc_unblocked;
  assign func_unit_rdy = {N_CH{reg_en}} & ifc_en;
  assign blocked       = ~rst & any_en & instr_done & ~ifc_unblocked;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (reg_en) begin
      stall_cnt <= '0;
    end else if (blocked && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (|(mem_vld & full)) begin
      ovf_err <= 1'b1;
    end
  end

  a_reg_en_unblk: assert property (@(posedge clk) disable iff (rst)
    reg_en |-> ifc_unblocked);
  a_pop_nonempty: assert property (@(posedge clk) disable iff (rst)
    (func_unit_rdy & empty) == '0);
  a_no_en_no_reg: assert property (@(posedge clk) disable iff (rst)
    (ifc_en == '0) |-> !reg_en);
endmodule

// File: tb/tb_pe_func_unit_ld_flow_ctrl_mc.sv
// Bench for the load flow controller: directed scenarios plus random traffic,
// all checked against a queue-based model of the channel buffers.
module tb_pe_func_unit_ld_flow_ctrl_mc;
  localparam int N_CH       = 2;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int STALL_W    = 8;
  localparam int STALL_MAX  = (1 << STALL_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_CH-1:0]        ifc_en;
  logic                   instr_done;
  logic                   ifc_unblocked;
  logic                   reg_en;
  logic [N_CH-1:0]        func_unit_rdy;
  logic [N_CH-1:0]        mem_vld;
  logic [N_CH*DATA_W-1:0] mem_data;
  logic [N_CH-1:0]        mem_rdy;
  logic [N_CH*DATA_W-1:0] rd_data;
  logic [STALL_W-1:0]     stall_cnt;
  logic                   ovf_err;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic [DATA_W-1:0] q [N_CH][$];
  int                m_stall;
  bit                m_ovf;

  always #5 clk = ~clk;

  pe_func_unit_ld_flow_ctrl_mc #(
    .N_CH(N_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .rst(rst), .ifc_en(ifc_en), .instr_done(instr_done),
    .ifc_unblocked(ifc_unblocked), .reg_en(reg_en), .func_unit_rdy(func_unit_rdy),
    .mem_vld(mem_vld), .mem_data(mem_data), .mem_rdy(mem_rdy), .rd_data(rd_data),
    .stall_cnt(stall_cnt), .ovf_err(ovf_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input bit r, input logic [N_CH-1:0] en, input bit done,
                     input logic [N_CH-1:0] vld, input logic [DATA_W-1:0] d0,
                     input logic [DATA_W-1:0] d1);
    logic [N_CH-1:0]        e_rdy;
    logic [N_CH-1:0]        e_fur;
    logic [N_CH*DATA_W-1:0] e_rd;
    bit                     e_unb;
    bit                     e_reg;
    rst = r; ifc_en = en; instr_done = done; mem_vld = vld; mem_data = {d1, d0};
    #1;
    e_unb = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      e_rdy[c] = (q[c].size() < FIFO_DEPTH);
      e_rd[c*DATA_W +: DATA_W] = (q[c].size() != 0) ? q[c][0] : '0;
      if (en[c] && q[c].size() == 0) e_unb = 1'b0;
    end
    e_reg = !r && (en != 0) && done && e_unb;
    e_fur = e_reg ? en : '0;
    if (chk_on) begin
      chk("ifc_unblocked", 64'(ifc_unblocked), 64'(e_unb));
      chk("reg_en", 64'(reg_en), 64'(e_reg));
      chk("func_unit_rdy", 64'(func_unit_rdy), 64'(e_fur));
      chk("mem_rdy", 64'(mem_rdy), 64'(e_rdy));
      chk("rd_data", 64'(rd_data), 64'(e_rd));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    end
    @(posedge clk);
    if (r) begin
      for (int c = 0; c < N_CH; c++) q[c].delete();
      m_stall = 0;
      m_ovf   = 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (vld[c] && !e_rdy[c]) m_ovf = 1'b1;
        if (e_fur[c]) void'(q[c].pop_front());
        if (vld[c] && e_rdy[c]) q[c].push_back(mem_data[c*DATA_W +: DATA_W]);
      end
      if (e_reg) m_stall = 0;
      else if ((en != 0) && done && !e_unb && m_stall < STALL_MAX) m_stall++;
    end
    @(negedge clk);
  endtask

  initial begin
    m_stall = 0;
    m_ovf   = 1'b0;
    @(negedge clk);
    cyc(1, 2'b00, 0, 2'b00, 0, 0);
    chk_on = 1'b1;
    cyc(1, 2'b00, 1, 2'b11, 32'h11, 32'h22);
    cyc(0, 2'b00, 1, 2'b00, 0, 0);

    // Staggered arrival: ch0 at t0, ch1 at t3, release at t4.
    cyc(0, 2'b00, 0, 2'b01, 32'hA, 0);
    cyc(0, 2'b11, 1, 2'b00, 0, 0);
    cyc(0, 2'b11, 1, 2'b00, 0, 0);
    cyc(0, 2'b11, 1, 2'b10, 0, 32'hB);
    chk("plan_stall_t4", 64'(stall_cnt), 64'd3);
    chk("plan_rd_t4", 64'(rd_data), {32'hB, 32'hA});
    cyc(0, 2'b11, 1, 2'b00, 0, 0);
    chk("plan_stall_t5", 64'(stall_cnt), 64'd0);
    cyc(0, 2'b00, 0, 2'b00, 0, 0);

    // Partial enable: only ch0 pops, ch1 keeps its word.
    cyc(0, 2'b00, 0, 2'b10, 0, 32'h5);
    cyc(0, 2'b00, 0, 2'b01, 32'h7, 0);
    cyc(0, 2'b01, 1, 2'b00, 0, 0);
    cyc(0, 2'b00, 0, 2'b00, 0, 0);
    cyc(0, 2'b10, 1, 2'b00, 0, 0);

    // Overflow: third word into a depth-2 FIFO is dropped and flagged.
    cyc(0, 2'b00, 0, 2'b01, 32'h1, 0);
    cyc(0, 2'b00, 0, 2'b01, 32'h2, 0);
    cyc(0, 2'b00, 0, 2'b01, 32'h3, 0);
    cyc(0, 2'b00, 0, 2'b00, 0, 0);
    cyc(0, 2'b01, 1, 2'b00, 0, 0);

    // Push and pop together while draining, crossing the pointer wrap.
    cyc(0, 2'b01, 1, 2'b01, 32'h4, 0);
    cyc(0, 2'b01, 1, 2'b01, 32'h5, 0);
    cyc(0, 2'b00, 0, 2'b01, 32'h6, 0);
    cyc(0, 2'b01, 1, 2'b00, 0, 0);
    cyc(0, 2'b01, 1, 2'b00, 0, 0);

    // Reset with data buffered and an instruction completing.
    cyc(0, 2'b00, 0, 2'b11, 32'h8, 32'h9);
    cyc(1, 2'b11, 1, 2'b00, 0, 0);
    cyc(0, 2'b00, 0, 2'b00, 0, 0);

    // Long stall drives the counter into saturation, then release clears it.
    for (int i = 0; i < 260; i++) cyc(0, 2'b10, 1, 2'b00, 0, 0);
    chk("stall_sat", 64'(stall_cnt), 64'(STALL_MAX));
    cyc(0, 2'b10, 0, 2'b10, 0, 32'hC);
    cyc(0, 2'b10, 1, 2'b00, 0, 0);
    cyc(0, 2'b00, 0, 2'b00, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 63) == 0), N_CH'($urandom), ($urandom_range(0, 3) != 0),
          N_CH'($urandom), $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
